gpu_clken_gen: RTL and testbench



---
 rtl/gpu_clk_pkg.sv | 26 ++
 rtl/gpu_clken_gen_if.sv | 28 ++
 rtl/gpu_clken_chan.sv | 33 +++
 rtl/gpu_clken_gen.sv | 112 +++++++++++
 tb/tb_gpu_clken_gen.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_clk_pkg.sv
// Shared types, constants and helpers for the GPU clock-enable generator.
package gpu_clk_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_e;

    localparam int unsigned LOCK_CYCLES_DEF = 16;

    // Widest channel index and divide field the request struct can carry.
    localparam int unsigned CH_W_MAX  = 4;
    localparam int unsigned DIV_W_MAX = 16;

    // Channel-select width; a single channel still needs one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [CH_W_MAX-1:0]  ch;
        logic [DIV_W_MAX-1:0] div;
        logic [DIV_W_MAX-1:0] phase;
    } cfg_req_t;

endpackage

// File: rtl/gpu_clken_gen_if.sv
// Configuration handshake and enable outputs of the clock-enable generator.
interface gpu_clken_gen_if
    import gpu_clk_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DIV_W  = 8
);
    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_phase;
    logic              cfg_err;
    logic [NUM_CH-1:0] clken;
    logic              locked;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_phase,
        input  cfg_ready, cfg_err, clken, locked
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
        output cfg_ready, cfg_err, clken, locked
    );
endinterface

// File: rtl/gpu_clken_chan.sv
// One enable channel: free-running modulo-div counter with a phase compare.
module gpu_clken_chan #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] phase,
    input  logic             run,
    input  logic             align_clr,
    output logic             clken_c
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Wrap at div-1 using a >= compare so the largest ratio never overflows.
    always_comb begin
        cnt_d = cnt_q;
        if (align_clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q >= div - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge refclk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign clken_c = run && (cnt_q == phase);

endmodule

// File: rtl/gpu_clken_gen.sv
// Multi-channel clock-enable generator with settle/lock sequencing.
module gpu_clken_gen
    import gpu_clk_pkg::*;
#(
    parameter int unsigned               NUM_CH       = 2,
    parameter int unsigned               DIV_W        = 8,
    parameter int unsigned               LOCK_CYCLES  = LOCK_CYCLES_DEF,
    parameter logic [NUM_CH*DIV_W-1:0]   DEFAULT_DIVS = {8'd1, 8'd4}
) (
    input  logic            refclk,
    input  logic            rst,
    gpu_clken_gen_if.slave  bus
);
    localparam int unsigned TMR_W = $clog2(LOCK_CYCLES) + 1;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [DIV_W-1:0]  div_q   [NUM_CH];
    logic [DIV_W-1:0]  div_d   [NUM_CH];
    logic [DIV_W-1:0]  phase_q [NUM_CH];
    logic [DIV_W-1:0]  phase_d [NUM_CH];
    logic              err_q, err_d;
    logic              run_c, align_clr_c, req_ok_c;
    logic [NUM_CH-1:0] clken_c;
    cfg_req_t          req_c;

    assign run_c = (state_q == RUN);

    // Widen the request so range checks never lose out-of-range channel bits.
    always_comb begin
        req_c       = '0;
        req_c.ch    = CH_W_MAX'(bus.cfg_ch);
        req_c.div   = DIV_W_MAX'(bus.cfg_div);
        req_c.phase = DIV_W_MAX'(bus.cfg_phase);
        req_ok_c    = (32'(req_c.ch) < NUM_CH) && (req_c.div != '0) &&
                      (req_c.phase < req_c.div);
    end

    // Next state: settle countdown, then accept or reject reconfiguration.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        div_d       = div_q;
        phase_d     = phase_q;
        err_d       = 1'b0;
        align_clr_c = 1'b0;
        case (state_q)
            SETTLE: begin
                if (tmr_q == '0) begin
                    state_d     = RUN;
                    align_clr_c = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RUN: begin
                if (bus.cfg_valid) begin
                    if (!req_ok_c) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (CH_W_MAX'(i) == req_c.ch) begin
                                div_d[i]   = DIV_W'(req_c.div);
                                phase_d[i] = DIV_W'(req_c.phase);
                            end
                        end
                        state_d = SETTLE;
                        tmr_d   = TMR_W'(LOCK_CYCLES - 1);
                    end
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    // State and configuration registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= SETTLE;
            tmr_q   <= TMR_W'(LOCK_CYCLES - 1);
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= DEFAULT_DIVS[i*DIV_W +: DIV_W];
                phase_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        gpu_clken_chan #(.DIV_W(DIV_W)) u_chan (
            .refclk    (refclk),
            .rst       (rst),
            .div       (div_q[g]),
            .phase     (phase_q[g]),
            .run       (run_c),
            .align_clr (align_clr_c),
            .clken_c   (clken_c[g])
        );
    end

    assign bus.cfg_ready = run_c;
    assign bus.locked    = run_c;
    assign bus.cfg_err   = err_q;
    assign bus.clken     = clken_c;

endmodule

// File: tb/tb_gpu_clken_gen.sv
// Self-checking bench for gpu_clken_gen against a cycle-count reference model.
module tb_gpu_clken_gen;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DIV_W  = 8;
    localparam int          LOCK   = 16;
    localparam logic [15:0] DEFS   = {8'd1, 8'd4};
    localparam logic [23:0] DEFS3  = {8'd2, 8'd1, 8'd4};

    logic refclk = 1'b0;
    logic rst;
    always #5 refclk = ~refclk;

    gpu_clken_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();
    gpu_clken_gen_if #(.NUM_CH(3), .DIV_W(DIV_W)) bus3 ();

    gpu_clken_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK),
                    .DEFAULT_DIVS(DEFS)) u_dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    gpu_clken_gen #(.NUM_CH(3), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK),
                    .DEFAULT_DIVS(DEFS3)) u_dut3 (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus3)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: cycles left in settle, cycles since RUN entry, config.
    int m_settle;
    int m_run;
    int m_div   [NUM_CH];
    int m_phase [NUM_CH];
    bit m_err;

    typedef struct {
        int ch;
        int div;
        int phase;
        bit exp_err;
    } inv_vec_t;

    inv_vec_t inv_tab [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_settle = LOCK;
            m_run    = 0;
            m_err    = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i]   = int'(DEFS[i*8 +: 8]);
                m_phase[i] = 0;
            end
        end else if (m_settle > 0) begin
            m_settle--;
            m_run = 0;
            m_err = 1'b0;
        end else if (bus.cfg_valid) begin
            if (int'(bus.cfg_div) == 0 || int'(bus.cfg_phase) >= int'(bus.cfg_div) ||
                int'(bus.cfg_ch) >= NUM_CH) begin
                m_err = 1'b1;
                m_run++;
            end else begin
                m_div[int'(bus.cfg_ch)]   = int'(bus.cfg_div);
                m_phase[int'(bus.cfg_ch)] = int'(bus.cfg_phase);
                m_settle = LOCK;
                m_run    = 0;
                m_err    = 1'b0;
            end
        end else begin
            m_run++;
            m_err = 1'b0;
        end
    endtask

    task automatic model_check();
        logic [NUM_CH-1:0] exp_en;
        for (int i = 0; i < NUM_CH; i++)
            exp_en[i] = (m_settle == 0) && ((m_run % m_div[i]) == m_phase[i]);
        chk("m_locked", 32'(bus.locked), 32'(m_settle == 0));
        chk("m_ready", 32'(bus.cfg_ready), 32'(m_settle == 0));
        chk("m_err", 32'(bus.cfg_err), 32'(m_err));
        chk("m_clken", 32'(bus.clken), 32'(exp_en));
    endtask

    task automatic cyc();
        @(posedge refclk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic wait_lock(input int max);
        int k = 0;
        while (!bus.locked && k < max) begin
            cyc();
            k++;
        end
        chk("wait_lock", 32'(bus.locked), 32'd1);
    endtask

    task automatic drive_cfg(input bit v, input int ch, input int div, input int ph);
        bus.cfg_valid = v;
        bus.cfg_ch    = 1'(ch);
        bus.cfg_div   = 8'(div);
        bus.cfg_phase = 8'(ph);
    endtask

    initial begin
        int t_strb [4];
        int n_strb;
        int t;

        inv_tab[0] = '{ch: 0, div: 0, phase: 0, exp_err: 1'b1};
        inv_tab[1] = '{ch: 0, div: 5, phase: 5, exp_err: 1'b1};
        inv_tab[2] = '{ch: 1, div: 5, phase: 9, exp_err: 1'b1};
        inv_tab[3] = '{ch: 1, div: 0, phase: 3, exp_err: 1'b1};

        rst = 1'b1;
        drive_cfg(1'b0, 0, 0, 0);
        bus3.cfg_valid = 1'b0;
        bus3.cfg_ch    = '0;
        bus3.cfg_div   = '0;
        bus3.cfg_phase = '0;

        // Reset with defaults: 16 unlocked cycles, then aligned strobes.
        repeat (3) cyc();
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_clken", 32'(bus.clken), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < LOCK - 1; k++) begin
            cyc();
            chk("settle_locked", 32'(bus.locked), 32'd0);
        end
        cyc();
        chk("first_lock", 32'(bus.locked), 32'd1);
        chk("first_clken", 32'(bus.clken), 32'b11);
        for (int r = 1; r <= 8; r++) begin
            cyc();
            chk("def_ch0", 32'(bus.clken[0]), 32'(r % 4 == 0));
            chk("def_ch1", 32'(bus.clken[1]), 32'd1);
        end

        // Valid reconfig ch0 div=3 phase=2.
        drive_cfg(1'b1, 0, 3, 2);
        cyc();
        drive_cfg(1'b0, 0, 0, 0);
        chk("rcfg_locked", 32'(bus.locked), 32'd0);
        chk("rcfg_ready", 32'(bus.cfg_ready), 32'd0);
        chk("rcfg_clken", 32'(bus.clken), 32'd0);
        for (int k = 0; k < LOCK - 1; k++) begin
            cyc();
            chk("rcfg_settle", 32'(bus.locked), 32'd0);
        end
        for (int r = 0; r <= 8; r++) begin
            cyc();
            chk("rcfg_ch0", 32'(bus.clken[0]), 32'(r % 3 == 2));
            chk("rcfg_ch1", 32'(bus.clken[1]), 32'd1);
        end

        // Invalid requests from the table: one-cycle error, lock kept.
        foreach (inv_tab[i]) begin
            drive_cfg(1'b1, inv_tab[i].ch, inv_tab[i].div, inv_tab[i].phase);
            cyc();
            drive_cfg(1'b0, 0, 0, 0);
            chk("inv_err", 32'(bus.cfg_err), 32'(inv_tab[i].exp_err));
            chk("inv_locked", 32'(bus.locked), 32'd1);
            cyc();
            chk("inv_err_clr", 32'(bus.cfg_err), 32'd0);
        end

        // Out-of-range channel on a 3-channel instance.
        chk("d3_locked", 32'(bus3.locked), 32'd1);
        bus3.cfg_valid = 1'b1;
        bus3.cfg_ch    = 2'd3;
        bus3.cfg_div   = 8'd2;
        bus3.cfg_phase = 8'd0;
        cyc();
        bus3.cfg_valid = 1'b0;
        chk("d3_err", 32'(bus3.cfg_err), 32'd1);
        chk("d3_locked2", 32'(bus3.locked), 32'd1);
        cyc();
        chk("d3_err_clr", 32'(bus3.cfg_err), 32'd0);

        // Backpressure: valid held through settle, accepted once on first RUN cycle.
        drive_cfg(1'b1, 1, 2, 1);
        cyc();
        drive_cfg(1'b1, 0, 4, 0);
        for (int k = 0; k < LOCK - 1; k++) begin
            cyc();
            chk("bp_ready", 32'(bus.cfg_ready), 32'd0);
        end
        cyc();
        chk("bp_ready_run", 32'(bus.cfg_ready), 32'd1);
        cyc();
        drive_cfg(1'b0, 0, 0, 0);
        chk("bp_relock", 32'(bus.locked), 32'd0);
        wait_lock(40);

        // Reset mid-settle after writing div=3: defaults and full settle return.
        drive_cfg(1'b1, 0, 3, 0);
        cyc();
        drive_cfg(1'b0, 0, 0, 0);
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < LOCK - 1; k++) begin
            cyc();
            chk("mid_settle", 32'(bus.locked), 32'd0);
        end
        for (int r = 0; r <= 8; r++) begin
            cyc();
            chk("mid_ch0", 32'(bus.clken[0]), 32'(r % 4 == 0));
            chk("mid_ch1", 32'(bus.clken[1]), 32'd1);
        end

        // Max ratio: ch1 div=255 phase=254, period 255 over three periods.
        drive_cfg(1'b1, 1, 255, 254);
        cyc();
        drive_cfg(1'b0, 0, 0, 0);
        wait_lock(40);
        n_strb = 0;
        t = 0;
        while (n_strb < 4 && t < 1100) begin
            if (bus.clken[1]) begin
                t_strb[n_strb] = t;
                n_strb++;
            end
            cyc();
            t++;
        end
        chk("max_count", 32'(n_strb), 32'd4);
        if (n_strb == 4) begin
            chk("max_first", 32'(t_strb[0]), 32'd254);
            for (int i = 1; i < 4; i++)
                chk("max_period", 32'(t_strb[i] - t_strb[i-1]), 32'd255);
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive_cfg($urandom_range(0, 5) == 0, int'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 9)),
                      int'($urandom_range(0, 9)));
            cyc();
        end
        rst = 1'b0;
        drive_cfg(1'b0, 0, 0, 0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
